// File: rtl/sr_cond_pkg.sv
// Shared constants and helpers for the SR flip-flop input conditioner.
package sr_cond_pkg;

  localparam int PRIO_RESET = 0;
  localparam int PRIO_SET   = 1;

  // Counter width for a debounce window of n cycles; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser, debounce counter and rising-edge detector.
module debounce_channel
  import sr_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  // Stable flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= CNT_ZERO;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      if (sync2 == stable) begin
        cnt <= CNT_ZERO;
      end else if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt    <= CNT_ZERO;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign level = stable;
  assign rise  = stable & ~stable_q;

endmodule

// File: rtl/sr_input_conditioner.sv
// Turns two raw buttons into mutually exclusive one-cycle S/R pulses for an SR flip-flop.
module sr_input_conditioner
  import sr_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRIORITY        = PRIO_RESET
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic reset_btn,
  output logic S,
  output logic R,
  output logic set_level,
  output logic reset_level,
  output logic conflict
);

  logic set_rise;
  logic reset_rise;
  logic s_next;
  logic r_next;
  logic conflict_next;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_ch (
    .clk   (clk),
    .rst   (rst),
    .raw   (set_btn),
    .level (set_level),
    .rise  (set_rise)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_ch (
    .clk   (clk),
    .rst   (rst),
    .raw   (reset_btn),
    .level (reset_level),
    .rise  (reset_rise)
  );

  // Same-cycle collision keeps exactly one pulse so S and R are never both high.
  always_comb begin
    s_next        = 1'b0;
    r_next        = 1'b0;
    conflict_next = 1'b0;
    case ({set_rise, reset_rise})
      2'b10: s_next = 1'b1;
      2'b01: r_next = 1'b1;
      2'b11: begin
        conflict_next = 1'b1;
        if (PRIORITY == PRIO_SET) begin
          s_next = 1'b1;
        end else begin
          r_next = 1'b1;
        end
      end
      default: begin
        s_next        = 1'b0;
        r_next        = 1'b0;
        conflict_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      S        <= s_next;
      R        <= r_next;
      conflict <= conflict_next;
    end
  end

endmodule
